// File: rtl/rrf_retire_ctrl_pkg.sv
// Shared sizing and types for the RRF retirement scheduler.
// Holds the default window geometry and the per-entry status record.
package rrf_retire_ctrl_pkg;

    localparam int DEF_RRF_NUM  = 64;
    localparam int DEF_RRF_SEL  = 6;
    localparam int COMMIT_WIDTH = 2;

    typedef struct packed {
        logic valid;
        logic done;
    } entry_t;

endpackage

// File: rtl/rrf_entry_status.sv
// Valid/done bit array of the RRF window: two clears, two sets,
// one allocate, two head read ports and liveness probes.
module rrf_entry_status
    import rrf_retire_ctrl_pkg::*;
#(
    parameter int RRF_NUM = DEF_RRF_NUM,
    parameter int RRF_SEL = DEF_RRF_SEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr0_en,
    input  logic [RRF_SEL-1:0] clr0_idx,
    input  logic               clr1_en,
    input  logic [RRF_SEL-1:0] clr1_idx,
    input  logic               set0_en,
    input  logic [RRF_SEL-1:0] set0_idx,
    input  logic               set1_en,
    input  logic [RRF_SEL-1:0] set1_idx,
    input  logic               alloc_en,
    input  logic [RRF_SEL-1:0] alloc_idx,
    input  logic [RRF_SEL-1:0] rd0_idx,
    input  logic [RRF_SEL-1:0] rd1_idx,
    output entry_t             rd0,
    output entry_t             rd1,
    output logic               alloc_live,
    output logic               set0_live,
    output logic               set1_live
);

    logic [RRF_NUM-1:0] valid_q, done_q;
    logic [RRF_NUM-1:0] valid_d, done_d;

    // Retire, then writeback, then allocate: later writes win per index.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (clr0_en) begin
            valid_d[clr0_idx] = 1'b0;
            done_d[clr0_idx]  = 1'b0;
        end
        if (clr1_en) begin
            valid_d[clr1_idx] = 1'b0;
            done_d[clr1_idx]  = 1'b0;
        end
        if (set0_en)
            done_d[set0_idx] = 1'b1;
        if (set1_en)
            done_d[set1_idx] = 1'b1;
        if (alloc_en) begin
            valid_d[alloc_idx] = 1'b1;
            done_d[alloc_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign rd0        = entry_t'{valid: valid_q[rd0_idx], done: done_q[rd0_idx]};
    assign rd1        = entry_t'{valid: valid_q[rd1_idx], done: done_q[rd1_idx]};
    assign alloc_live = valid_q[alloc_idx];
    assign set0_live  = valid_q[set0_idx];
    assign set1_live  = valid_q[set1_idx];

endmodule

// File: rtl/rrf_retire_ctrl.sv
// RRF retirement scheduler: in-order retire of up to two done entries
// per cycle, with commit pointer, in-flight count and sticky error flag.
module rrf_retire_ctrl
    import rrf_retire_ctrl_pkg::*;
#(
    parameter int RRF_NUM = DEF_RRF_NUM,
    parameter int RRF_SEL = DEF_RRF_SEL
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               alloc_valid_i,
    input  logic [RRF_SEL-1:0] alloc_tag_i,
    input  logic               wb0_valid_i,
    input  logic [RRF_SEL-1:0] wb0_tag_i,
    input  logic               wb1_valid_i,
    input  logic [RRF_SEL-1:0] wb1_tag_i,
    input  logic               commit_en_i,
    output logic [1:0]         com_inst_num_o,
    output logic               com0_valid_o,
    output logic [RRF_SEL-1:0] com0_tag_o,
    output logic               com1_valid_o,
    output logic [RRF_SEL-1:0] com1_tag_o,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic [RRF_SEL:0]   inflight_o,
    output logic               empty_o,
    output logic               err_o
);

    logic [RRF_SEL-1:0] comptr;
    logic [RRF_SEL-1:0] comptr_nx;
    logic [RRF_SEL:0]   inflight;
    logic               err;
    entry_t             head0, head1;
    logic               alloc_live, wb0_live, wb1_live;
    logic               c0, c1;
    logic [1:0]         num;
    logic               alloc_retiring;
    logic               err_now;

    assign comptr_nx = comptr + {{(RRF_SEL-1){1'b0}}, 1'b1};

    rrf_entry_status #(
        .RRF_NUM (RRF_NUM),
        .RRF_SEL (RRF_SEL)
    ) u_status (
        .clk        (clk_i),
        .rst        (reset_i),
        .clr0_en    (c0),
        .clr0_idx   (comptr),
        .clr1_en    (c1),
        .clr1_idx   (comptr_nx),
        .set0_en    (wb0_valid_i),
        .set0_idx   (wb0_tag_i),
        .set1_en    (wb1_valid_i),
        .set1_idx   (wb1_tag_i),
        .alloc_en   (alloc_valid_i),
        .alloc_idx  (alloc_tag_i),
        .rd0_idx    (comptr),
        .rd1_idx    (comptr_nx),
        .rd0        (head0),
        .rd1        (head1),
        .alloc_live (alloc_live),
        .set0_live  (wb0_live),
        .set1_live  (wb1_live)
    );

    assign c0  = commit_en_i & head0.valid & head0.done;
    assign c1  = c0 & head1.valid & head1.done;
    assign num = {1'b0, c0} + {1'b0, c1};

    // Reusing a slot that leaves this very edge is legal (full window).
    assign alloc_retiring = (c0 & (alloc_tag_i == comptr))
                          | (c1 & (alloc_tag_i == comptr_nx));

    assign err_now = (alloc_valid_i & alloc_live & ~alloc_retiring)
                   | (wb0_valid_i & ~wb0_live)
                   | (wb1_valid_i & ~wb1_live)
                   | (alloc_valid_i & wb0_valid_i & (wb0_tag_i == alloc_tag_i))
                   | (alloc_valid_i & wb1_valid_i & (wb1_tag_i == alloc_tag_i))
                   | (wb0_valid_i & wb1_valid_i & (wb0_tag_i == wb1_tag_i));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            comptr   <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            comptr   <= comptr + {{(RRF_SEL-2){1'b0}}, num};
            inflight <= inflight
                      + {{RRF_SEL{1'b0}}, alloc_valid_i}
                      - {{(RRF_SEL-1){1'b0}}, num};
            err      <= err | err_now;
        end
    end

    assign com_inst_num_o = num;
    assign com0_valid_o   = c0;
    assign com1_valid_o   = c1;
    assign com0_tag_o     = comptr;
    assign com1_tag_o     = comptr_nx;
    assign comptr_o       = comptr;
    assign inflight_o     = inflight;
    assign empty_o        = (inflight == '0);
    assign err_o          = err;

endmodule

// File: tb/tb_rrf_retire_ctrl.sv
// Vector-table bench for rrf_retire_ctrl with a queue scoreboard
// plus an asynchronous mid-cycle reset sequence.
module tb_rrf_retire_ctrl;

    typedef struct {
        bit       rst;
        bit       av;
        bit [5:0] at;
        bit       w0v;
        bit [5:0] w0t;
        bit       w1v;
        bit [5:0] w1t;
        bit       cen;
        int       num;
        int       cp;
        int       inf;
        bit       er;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       alloc_valid_i = 1'b0;
    logic [5:0] alloc_tag_i = '0;
    logic       wb0_valid_i = 1'b0;
    logic [5:0] wb0_tag_i = '0;
    logic       wb1_valid_i = 1'b0;
    logic [5:0] wb1_tag_i = '0;
    logic       commit_en_i = 1'b1;
    logic [1:0] com_inst_num_o;
    logic       com0_valid_o;
    logic [5:0] com0_tag_o;
    logic       com1_valid_o;
    logic [5:0] com1_tag_o;
    logic [5:0] comptr_o;
    logic [6:0] inflight_o;
    logic       empty_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl[$];
    vec_t sb[$];

    rrf_retire_ctrl dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_tag_i    (alloc_tag_i),
        .wb0_valid_i    (wb0_valid_i),
        .wb0_tag_i      (wb0_tag_i),
        .wb1_valid_i    (wb1_valid_i),
        .wb1_tag_i      (wb1_tag_i),
        .commit_en_i    (commit_en_i),
        .com_inst_num_o (com_inst_num_o),
        .com0_valid_o   (com0_valid_o),
        .com0_tag_o     (com0_tag_o),
        .com1_valid_o   (com1_valid_o),
        .com1_tag_o     (com1_tag_o),
        .comptr_o       (comptr_o),
        .inflight_o     (inflight_o),
        .empty_o        (empty_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(bit r, bit av, int at, bit w0v, int w0t,
                                bit w1v, int w1t, bit cen,
                                int num, int cp, int inf, bit er);
        vec_t v;
        v.rst = r;   v.av = av;   v.at = 6'(at);
        v.w0v = w0v; v.w0t = 6'(w0t);
        v.w1v = w1v; v.w1t = 6'(w1t);
        v.cen = cen;
        v.num = num; v.cp = cp; v.inf = inf; v.er = er;
        return v;
    endfunction

    function automatic vec_t rs();
        return mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    function automatic vec_t idle(bit cen, int num, int cp, int inf, bit er);
        return mk(0, 0, 0, 0, 0, 0, 0, cen, num, cp, inf, er);
    endfunction

    task automatic check(string name, int step, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d want %0d", name, step, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset_i       = v.rst;
        alloc_valid_i = v.av;
        alloc_tag_i   = v.at;
        wb0_valid_i   = v.w0v;
        wb0_tag_i     = v.w0t;
        wb1_valid_i   = v.w1v;
        wb1_tag_i     = v.w1t;
        commit_en_i   = v.cen;
    endtask

    initial begin
        vec_t e;

        // In-order retire with out-of-order writeback.
        tbl.push_back(rs());
        tbl.push_back(idle(1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 3, 0));
        tbl.push_back(idle(1, 2, 1, 2, 0));
        tbl.push_back(idle(1, 0, 3, 0, 0));

        // Dual writeback, dual retire.
        tbl.push_back(rs());
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 2, 0));
        tbl.push_back(idle(1, 2, 0, 2, 0));
        tbl.push_back(idle(1, 0, 2, 0, 0));

        // Stream tags 0..61 through to bring comptr to 62.
        tbl.push_back(rs());
        for (int i = 0; i < 62; i++)
            tbl.push_back(mk(0, 1, i, i >= 1, (i >= 1) ? i - 1 : 0, 0, 0, 1,
                             (i >= 2) ? 1 : 0, (i >= 2) ? i - 2 : 0,
                             (i < 2) ? i : 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 61, 0, 0, 1, 1, 60, 2, 0));
        tbl.push_back(idle(1, 1, 61, 1, 0));
        tbl.push_back(idle(1, 0, 62, 0, 0));
        // Wrap: 62,63 retire together, then 0.
        tbl.push_back(mk(0, 1, 62, 0, 0, 0, 0, 0, 0, 62, 0, 0));
        tbl.push_back(mk(0, 1, 63, 1, 62, 0, 0, 0, 0, 62, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 63, 0, 0, 0, 0, 62, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 62, 3, 0));
        tbl.push_back(idle(1, 1, 0, 1, 0));
        tbl.push_back(idle(1, 0, 1, 0, 0));

        // Full window, reuse of the retiring head slot.
        tbl.push_back(rs());
        for (int i = 0; i < 64; i++)
            tbl.push_back(mk(0, 1, i, 0, 0, 0, 0, 1, 0, 0, i, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 64, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 64, 0));
        tbl.push_back(idle(1, 0, 1, 64, 0));

        // Commit back-pressure.
        tbl.push_back(rs());
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, i, 0, 0, 0, 0, 1, 0, 0, i, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 3, 0, 0, 0, 4, 0));
        tbl.push_back(idle(0, 0, 0, 4, 0));
        tbl.push_back(idle(0, 0, 0, 4, 0));
        tbl.push_back(idle(1, 2, 0, 4, 0));
        tbl.push_back(idle(1, 2, 2, 2, 0));
        tbl.push_back(idle(1, 0, 4, 0, 0));

        // Sticky errors: unallocated writeback, duplicate writeback tags.
        tbl.push_back(rs());
        tbl.push_back(mk(0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 1));
        tbl.push_back(idle(1, 0, 0, 0, 1));
        tbl.push_back(rs());
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 1, 7, 1, 0, 0, 1, 0));
        tbl.push_back(idle(1, 0, 0, 1, 1));
        tbl.push_back(idle(1, 0, 0, 1, 1));
        tbl.push_back(rs());

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk_i);
            #1;
            drive(tbl[k]);
            sb.push_back(tbl[k]);
            @(negedge clk_i);
            e = sb.pop_front();
            check("num",    k, int'(com_inst_num_o), e.num);
            check("c0v",    k, int'(com0_valid_o), (e.num >= 1) ? 1 : 0);
            check("c1v",    k, int'(com1_valid_o), (e.num == 2) ? 1 : 0);
            check("tag0",   k, int'(com0_tag_o), e.cp);
            check("tag1",   k, int'(com1_tag_o), (e.cp + 1) % 64);
            check("comptr", k, int'(comptr_o), e.cp);
            check("inflt",  k, int'(inflight_o), e.inf);
            check("empty",  k, int'(empty_o), (e.inf == 0) ? 1 : 0);
            check("err",    k, int'(err_o), int'(e.er));
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk_i);
        #1;
        reset_i       = 1'b0;
        alloc_valid_i = 1'b1;
        alloc_tag_i   = 6'd9;
        wb0_valid_i   = 1'b0;
        wb1_valid_i   = 1'b0;
        commit_en_i   = 1'b1;
        @(posedge clk_i);
        #1;
        alloc_valid_i = 1'b0;
        @(negedge clk_i);
        check("mid_inf_pre",  9000, int'(inflight_o), 1);
        check("mid_empty_pre", 9000, int'(empty_o), 0);
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_inf",   9001, int'(inflight_o), 0);
        check("mid_empty", 9001, int'(empty_o), 1);
        check("mid_cp",    9001, int'(comptr_o), 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        check("post_inf", 9002, int'(inflight_o), 0);
        check("sb_drain", 9003, sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rrf_retire_ctrl.md
# rrf_retire_ctrl

Retirement scheduler for the rename register file (RRF). It tracks every RRF entry that dispatch has allocated and marks each one done when an execution writeback reports it. It retires up to two of the oldest done entries per cycle, in allocation order. Its commit count drives the allocator's `com_inst_num_i`, and its commit tags drive the ARF update.

## Interface
Parameters:
- `RRF_NUM`, default `` `RRF_NUM `` (64): number of RRF entries; must be a power of 2.
- `RRF_SEL`, default `` `RRF_SEL `` (6): log2(`RRF_NUM`), the tag width.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `alloc_valid_i` in 1: dispatch allocated one entry this cycle (the allocator's not-stalled condition).
- `alloc_tag_i` in `RRF_SEL`: the allocated tag (the allocator's `dst_rename_rrftag_o`).
- `wb0_valid_i` in 1 / `wb0_tag_i` in `RRF_SEL`: writeback port 0 completion.
- `wb1_valid_i` in 1 / `wb1_tag_i` in `RRF_SEL`: writeback port 1 completion.
- `commit_en_i` in 1: when 0, no retirement this cycle (back-pressure from ARF/store path).
- `com_inst_num_o` out 2: entries retired at the coming edge (0..2).
- `com0_valid_o` out 1 / `com0_tag_o` out `RRF_SEL`: oldest retiring entry.
- `com1_valid_o` out 1 / `com1_tag_o` out `RRF_SEL`: second retiring entry.
- `comptr_o` out `RRF_SEL`: tag of the oldest in-flight entry.
- `inflight_o` out `RRF_SEL+1`: number of allocated, not-yet-retired entries.
- `empty_o` out 1: `inflight_o == 0`.
- `err_o` out 1: sticky protocol-error flag.

## Operation
State:
- `valid[RRF_NUM]`, `done[RRF_NUM]`, `comptr`, `inflight`, `err`.

Commit decision (combinational from registered state, no input-to-output path except through `commit_en_i`):
- `c0 = commit_en_i & valid[comptr] & done[comptr]`
- `c1 = c0 & valid[comptr+1] & done[comptr+1]`; the index wraps mod `RRF_NUM`.
- `com0_tag_o = comptr`, `com1_tag_o = comptr+1` (mod `RRF_NUM`). `com0_valid_o = c0`, `com1_valid_o = c1`.
- `com_inst_num_o = c0 + c1`.
- Never retire past an undone entry; out-of-order done entries wait.

Updates at each edge, applied in this order (later wins on the same index):
1. Retire: clear `valid`/`done` of committed entries; `comptr += com_inst_num_o` (mod `RRF_NUM`).
2. Writeback: `done[wbX_tag] <= 1` for each valid port.
3. Allocate: `valid[alloc_tag] <= 1`, `done[alloc_tag] <= 0`.
- `inflight <= inflight + alloc_valid_i - com_inst_num_o`, computed at `RRF_SEL+1` bits; it never exceeds `RRF_NUM`.

`err` is set, and stays set until reset, on any of:
- Allocation to an entry that is valid and not retiring this cycle.
- Writeback to an entry that is not valid.
- Writeback to the tag being allocated this same cycle.
- `wb0` and `wb1` carrying the same tag in one cycle.

Error handling otherwise follows the update rules above; the block does not drop the operation.

## Timing
- Reset: all `valid`/`done` = 0, `comptr` = 0, `inflight` = 0, `err` = 0. Hence `com_inst_num_o` = 0, `com*_valid_o` = 0, tags = 0/1, `comptr_o` = 0, `inflight_o` = 0, `empty_o` = 1, `err_o` = 0.
- Reset asserted mid-operation discards all in-flight state immediately; the allocator is reset on the same reset.
- Latency:
  - Allocation at edge N.
  - Writeback presented in cycle M ≥ N+1 sets `done` at edge M.
  - Earliest `com0_valid_o` is cycle M+1, and the entry retires at edge M+1.
  - Minimum alloc-to-retire time is 2 edges after the allocating edge.
- The allocator samples `com_inst_num_o` at the same edge at which the entries are cleared, so freed entries are reusable from the next cycle.
- Full window (`inflight` = `RRF_NUM`): allocating into `comptr` while it retires this cycle is legal.
- Wrap-around: `comptr` = `RRF_NUM-1` retiring 2 moves to 1.

## Structure
- `RRF_NUM`/`RRF_SEL` come from the shared consts file `Consts.v`. Add `` `COMMIT_WIDTH `` = 2 there.
- One natural sub-module: `rrf_entry_status`, the `valid`/`done` bit array with write ports for 2 clears, 2 sets, and 1 allocate, plus 2 read ports at `comptr` and `comptr+1`. The top level holds the pointer, counter, and error logic.

## Test plan
- Reset, then allocate tags 0,1,2 on consecutive cycles and write back 2,0,1 one per cycle. Required: nothing retires until tag 0 is done; then tag 0 retires alone (`com_inst_num_o` = 1), then tags 1 and 2 retire together (2); `comptr_o` = 3 and `empty_o` = 1 at the end.
- Allocate 0,1 and write back both in one cycle via wb0/wb1. Required: the next cycle shows `com_inst_num_o` = 2 with tags 0 and 1; `inflight_o` goes 2→0.
- Wrap: fill tags 62,63,0 (`comptr` = 62) and mark all done. Required: 62 and 63 retire first, then 0 (`com1_tag_o` = 63, then `comptr_o` = 0 → 1).
- Full window: 64 allocations, with `done` set on `comptr` only. Required: `inflight_o` = 64; allocating tag `comptr` in the retire cycle gives no `err_o` and `inflight_o` stays 64.
- Hold `commit_en_i` = 0 with 4 done entries. Required: `com_inst_num_o` = 0 throughout; on release, retire 2, then 2.
- Write back to an unallocated tag 5, and separately give both writeback ports the same tag. Required: `err_o` rises the next cycle and stays 1 until `reset_i`.
